apuf_crp_sequencer: RTL and testbench

//  Challenge-response sequencer directly upstream of the 8-way XOR arbiter-PUF array.

---
 rtl/apuf_crp_sequencer.sv | 134 +++++++++++++
 tb/tb_apuf_crp_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_crp_sequencer.sv
// ---------------------------------------------------------------------------
// apuf_crp_sequencer: challenge/response sequencer for an XOR arbiter-PUF array
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apuf_crp_sequencer #(
  parameter int CHAL_W        = 32,
  parameter int RESP_W        = 8,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [CHAL_W-1:0] Chal_in,
  input  logic              Chal_valid,
  output logic              Chal_ready,
  output logic [CHAL_W-1:0] PUF_Challenge,
  output logic              PUF_Reset,
  output logic              PUF_Pulse,
  input  logic [RESP_W-1:0] PUF_Result,
  output logic [RESP_W-1:0] Resp_out,
  output logic [CHAL_W-1:0] Resp_chal,
  output logic              Resp_valid,
  input  logic              Resp_ready,
  output logic              Busy,
  output logic [15:0]       Crp_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FIRE   = 3'd2,
    S_SAMPLE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         crp_count_q, crp_count_d;
  logic [RESP_W-1:0]   sync1_q, sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    crp_count_d  = crp_count_q;
    case (state_q)
      S_IDLE: begin
        if (Chal_valid) begin
          chal_d  = Chal_in;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == C_RST_LAST) begin
          cnt_d   = '0;
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        resp_d  = sync2_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Valid is raised one cycle into HOLD, so a handshake needs it already visible.
        if (resp_valid_q && Resp_ready) begin
          crp_count_d = crp_count_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      chal_q       <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      crp_count_q  <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      crp_count_q  <= crp_count_d;
      sync1_q      <= PUF_Result;
      sync2_q      <= sync1_q;
    end
  end

  assign Chal_ready    = (state_q == S_IDLE);
  assign Busy          = (state_q != S_IDLE);
  assign PUF_Reset     = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign PUF_Pulse     = (state_q == S_FIRE) || (state_q == S_SAMPLE) || (state_q == S_HOLD);
  assign PUF_Challenge = chal_q;
  assign Resp_chal     = chal_q;
  assign Resp_out      = resp_q;
  assign Resp_valid    = resp_valid_q;
  assign Crp_count     = crp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_apuf_crp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apuf_crp_sequencer: directed self-checking bench for apuf_crp_sequencer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apuf_crp_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] Chal_in = '0;
  logic        Chal_valid = 1'b0;
  logic        Chal_ready;
  logic [31:0] PUF_Challenge;
  logic        PUF_Reset;
  logic        PUF_Pulse;
  logic [7:0]  PUF_Result = '0;
  logic [7:0]  Resp_out;
  logic [31:0] Resp_chal;
  logic        Resp_valid;
  logic        Resp_ready = 1'b0;
  logic        Busy;
  logic [15:0] Crp_count;

  int total = 0;
  int bad   = 0;

  apuf_crp_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Chal_in(Chal_in), .Chal_valid(Chal_valid),
    .Chal_ready(Chal_ready), .PUF_Challenge(PUF_Challenge), .PUF_Reset(PUF_Reset),
    .PUF_Pulse(PUF_Pulse), .PUF_Result(PUF_Result), .Resp_out(Resp_out),
    .Resp_chal(Resp_chal), .Resp_valid(Resp_valid), .Resp_ready(Resp_ready),
    .Busy(Busy), .Crp_count(Crp_count)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Presents a challenge for one cycle; returns at the negedge after the accepting edge.
  task automatic send_chal(input logic [31:0] c);
    Chal_in    = c;
    Chal_valid = 1'b1;
    @(negedge Clk);
    Chal_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({Chal_ready, PUF_Reset, PUF_Pulse, Resp_valid, Busy} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 11000", {Chal_ready, PUF_Reset, PUF_Pulse, Resp_valid, Busy});
    end
    total++;
    if ({PUF_Challenge, Resp_chal, Resp_out, Crp_count} !== '0) begin
      bad++;
      $display("FAIL reset_data got %h %h %h %h want zeros", PUF_Challenge, Resp_chal, Resp_out, Crp_count);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic;
    int rst_cnt = 0;
    int pls_cnt = 0;
    PUF_Result = 8'h3C;
    step(3);
    send_chal(32'hA5A5_0F0F);
    Chal_in = 32'hFFFF_FFFF;
    for (int j = 0; j < 22; j++) begin
      if (PUF_Reset) rst_cnt++;
      if (PUF_Pulse && j < 20) pls_cnt++;
      total++;
      if (PUF_Reset !== (j < 4) || PUF_Pulse !== (j >= 4)) begin
        bad++;
        $display("FAIL phase j=%0d got rst=%b pulse=%b want rst=%b pulse=%b", j, PUF_Reset, PUF_Pulse, j < 4, j >= 4);
      end
      total++;
      if (Resp_valid !== 1'b0 || Chal_ready !== 1'b0 || Busy !== 1'b1) begin
        bad++;
        $display("FAIL early_flags j=%0d got valid=%b ready=%b busy=%b want 0 0 1", j, Resp_valid, Chal_ready, Busy);
      end
      total++;
      if (PUF_Challenge !== 32'hA5A5_0F0F) begin
        bad++;
        $display("FAIL chal_stable j=%0d got %h want a5a50f0f", j, PUF_Challenge);
      end
      step(1);
    end
    total++;
    if (rst_cnt != 4 || pls_cnt != 16) begin
      bad++;
      $display("FAIL phase_len got rst=%0d pulse=%0d want 4 16", rst_cnt, pls_cnt);
    end
    total++;
    if (Resp_valid !== 1'b1 || Resp_out !== 8'h3C || Resp_chal !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL basic_resp got v=%b %h %h want 1 3c a5a50f0f", Resp_valid, Resp_out, Resp_chal);
    end
    total++;
    if (PUF_Pulse !== 1'b1 || PUF_Reset !== 1'b0) begin
      bad++;
      $display("FAIL hold_pins got rst=%b pulse=%b want 0 1", PUF_Reset, PUF_Pulse);
    end
    Resp_ready = 1'b1;
    step(1);
    Resp_ready = 1'b0;
    total++;
    if (Resp_valid !== 1'b0 || Crp_count !== 16'd1 || Chal_ready !== 1'b1 ||
        PUF_Reset !== 1'b1 || PUF_Pulse !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got v=%b cnt=%0d rdy=%b rst=%b pls=%b busy=%b want 0 1 1 1 0 0",
               Resp_valid, Crp_count, Chal_ready, PUF_Reset, PUF_Pulse, Busy);
    end
  endtask

  task automatic test_hold_stall;
    PUF_Result = 8'h5A;
    step(1);
    send_chal(32'h1234_5678);
    step(22);
    total++;
    if (Resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_valid got %b want 1", Resp_valid);
    end
    for (int k = 0; k < 10; k++) begin
      Chal_in    = 32'hDEAD_0000 + 32'(k);
      Chal_valid = k[0];
      PUF_Result = 8'(k * 7);
      step(1);
      total++;
      if (Resp_valid !== 1'b1 || Resp_out !== 8'h5A || Resp_chal !== 32'h1234_5678 ||
          Chal_ready !== 1'b0 || PUF_Challenge !== 32'h1234_5678) begin
        bad++;
        $display("FAIL stall k=%0d got v=%b %h %h rdy=%b pc=%h want 1 5a 12345678 0 12345678",
                 k, Resp_valid, Resp_out, Resp_chal, Chal_ready, PUF_Challenge);
      end
    end
    Chal_valid = 1'b0;
    Resp_ready = 1'b1;
    step(1);
    Resp_ready = 1'b0;
    total++;
    if (Chal_ready !== 1'b1 || Crp_count !== 16'd2) begin
      bad++;
      $display("FAIL stall_release got rdy=%b cnt=%0d want 1 2", Chal_ready, Crp_count);
    end
    step(2);
    total++;
    if (Crp_count !== 16'd2 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_once got cnt=%0d busy=%b want 2 0", Crp_count, Busy);
    end
  endtask

  task automatic test_back_to_back;
    int t[3] = '{-1, -1, -1};
    int n = 0;
    Rst_n = 1'b0;
    step(1);
    Rst_n = 1'b1;
    PUF_Result = 8'hC3;
    Chal_in    = 32'hCAFE_0001;
    step(1);
    Chal_valid = 1'b1;
    Resp_ready = 1'b1;
    step(1);
    for (int c = 0; c < 120; c++) begin
      if (Resp_valid === 1'b1) begin
        t[n] = c;
        n++;
        if (n == 3) break;
      end
      step(1);
    end
    Chal_valid = 1'b0;
    step(1);
    Resp_ready = 1'b0;
    total++;
    if (t[0] != 22) begin
      bad++;
      $display("FAIL b2b_first got %0d want 22", t[0]);
    end
    total++;
    if (t[1] - t[0] != 24 || t[2] - t[1] != 24) begin
      bad++;
      $display("FAIL b2b_spacing got %0d %0d want 24 24", t[1] - t[0], t[2] - t[1]);
    end
    total++;
    if (Crp_count !== 16'd3 || Resp_out !== 8'hC3) begin
      bad++;
      $display("FAIL b2b_count got cnt=%0d resp=%h want 3 c3", Crp_count, Resp_out);
    end
  endtask

  task automatic test_reset_mid;
    step(2);
    send_chal(32'h5555_AAAA);
    step(10);
    Rst_n = 1'b0;
    #1;
    total++;
    if ({Chal_ready, PUF_Reset, PUF_Pulse, Resp_valid, Busy} !== 5'b11000) begin
      bad++;
      $display("FAIL midrst_ctrl got %b want 11000", {Chal_ready, PUF_Reset, PUF_Pulse, Resp_valid, Busy});
    end
    total++;
    if ({PUF_Challenge, Resp_chal, Resp_out, Crp_count} !== '0) begin
      bad++;
      $display("FAIL midrst_data got %h %h %h %h want zeros", PUF_Challenge, Resp_chal, Resp_out, Crp_count);
    end
    step(3);
    Rst_n = 1'b1;
    total++;
    if (Resp_valid !== 1'b0 || Crp_count !== 16'd0) begin
      bad++;
      $display("FAIL midrst_hold got v=%b cnt=%0d want 0 0", Resp_valid, Crp_count);
    end
    PUF_Result = 8'h77;
    step(2);
    send_chal(32'h0BAD_F00D);
    step(22);
    total++;
    if (Resp_valid !== 1'b1 || Resp_out !== 8'h77 || Resp_chal !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL midrst_next got v=%b %h %h want 1 77 0badf00d", Resp_valid, Resp_out, Resp_chal);
    end
    Resp_ready = 1'b1;
    step(1);
    Resp_ready = 1'b0;
    total++;
    if (Crp_count !== 16'd1) begin
      bad++;
      $display("FAIL midrst_count got %0d want 1", Crp_count);
    end
  endtask

  task automatic test_wrap_sync;
    step(1);
    force dut.crp_count_q = 16'hFFFF;
    step(1);
    release dut.crp_count_q;
    PUF_Result = 8'hA1;
    step(1);
    total++;
    if (Crp_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL preload got %h want ffff", Crp_count);
    end
    send_chal(32'h0000_FFFF);
    step(19);
    // Change lands after the last edge the two-stage synchroniser can carry into the sample.
    PUF_Result = 8'h1E;
    step(3);
    total++;
    if (Resp_valid !== 1'b1 || Resp_out !== 8'hA1) begin
      bad++;
      $display("FAIL sync_depth got v=%b resp=%h want 1 a1", Resp_valid, Resp_out);
    end
    Resp_ready = 1'b1;
    step(1);
    Resp_ready = 1'b0;
    total++;
    if (Crp_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap got %h want 0000", Crp_count);
    end
  endtask

  always @(negedge Clk) begin
    if (PUF_Reset && PUF_Pulse) begin
      total++;
      bad++;
      $display("FAIL pins_exclusive got rst=1 pulse=1 want not both");
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
